pe_conf_sequencer: RTL and testbench
====================================

// Module: pe_conf_sequencer
// PURPOSE
// Sequences one PE column's datapath controller through a stream of layer/tile configurations.
// Accepts Conf descriptors over a rdy/ack link and holds one pending descriptor in a shadow slot.
// Drives the controller's Conf and Inst (dval/start/reset/next/stall) and watches DPstatus.confEnd.
// Sits between the global tile scheduler and the per-PE DataPathController; provides back-to-back
// issue, hold (stall) and abort.
// PARAMETERS
// CNTW      8  width of completed-configuration counter o_confCnt (wraps)
// PREFETCH  1  1: shadow slot accepts next Conf while running; 0: Conf_ack only in IDLE
// PORTS
// i_clk        in   1          clock
// i_rstn       in   1          async active-low reset
// Conf_rdy     in   1          upstream descriptor valid
// Conf_ack     out  1          descriptor accepted (transfer = Conf_rdy && Conf_ack)
// i_conf       in   Conf       descriptor payload
// i_hold       in   1          downstream backpressure; request controller stall
// i_abort      in   1          flush: kill active and pending configuration
// i_dpstatus   in   DPstatus   controller status (confEnd used)
// o_PEconf     out  Conf       active configuration to controller (registered)
// o_PEinst     out  Inst       instruction to controller
// o_busy       out  1          state != IDLE or shadow valid
// o_confDone   out  1          1-cycle pulse per completed configuration
// o_confCnt    out  CNTW       completed configurations, wraps at 2^CNTW
// BEHAVIOUR
// - Reset: state IDLE, shadow empty, o_PEconf='0, o_PEinst='0, o_confDone=0, o_confCnt=0, armed=0.
// - Conf_ack = !shadow_v && !i_abort && (PREFETCH || state==IDLE); accepted payload loads shadow next edge.
// - States: IDLE, START, WARM, RUN, ABORT.
// - IDLE: Inst='0. If shadow_v -> START; on that edge active<=shadow, shadow_v<=0.
// - START: Inst={dval=1,start=1,reset=1} (clears controller loop counters, kicks IDLE->INIT) -> WARM.
// - WARM: Inst={dval=1}; controller passes INIT->WORK -> RUN; armed<=0.
// - RUN: Inst={dval=1,stall=i_hold} (combinational from i_hold). armed<=1 after first RUN cycle.
//   confEnd is ignored while armed==0 (stale status is held across IDLE by the controller's clock gate).
//   confEnd && armed: o_confDone=1 next cycle, o_confCnt+=1; if shadow_v -> START (copy shadow), else IDLE.
// - Latency: Conf accepted at t with sequencer IDLE -> START at t+2, WARM t+3, RUN t+4.
//   confEnd at t with shadow valid -> START t+1 (back-to-back, no IDLE cycle).
// - ABORT: entered from START/WARM/RUN when i_abort=1 (priority over confEnd and i_hold same cycle).
//   Drives Inst={dval=1,reset=1}, shadow_v<=0, no count/pulse -> IDLE. i_abort in IDLE flushes shadow only.
// - i_hold in START/WARM: not forwarded (controller ignores stall there); takes effect from RUN.
// - Shadow full and Conf_rdy high: Conf_ack=0, payload not sampled; no loss, no overwrite.
// - o_PEconf changes only on IDLE->START or RUN->START edges; stable for the whole configuration.
// - o_confCnt wraps 2^CNTW-1 -> 0 silently.
// STRUCTURE
// - PECtlCfg: add SeqState enum {IDLE,START,WARM,RUN,ABORT}; reuse Conf/Inst/DPstatus from PECfg/PECtlCfg.
// - One sub-module: pe_conf_slot (single-entry Conf register with valid, load/take, flush).
// - All state/outputs in registers under ff_rstn macros; Inst decode is combinational from state.
// TESTING
// - Single Conf, no hold: Conf_rdy at t=2 -> START t=4 (start=reset=1), RUN t=6; confEnd -> IDLE, cnt=1.
// - Two Confs queued (PREFETCH=1): 2nd acked during RUN; confEnd -> START next cycle, o_PEconf=2nd, cnt=2.
// - Stale confEnd held high at entry to RUN -> not counted; completes only on later confEnd (armed=1).
// - i_hold asserted 5 cycles in RUN -> o_PEinst.stall=1 exactly those cycles; no state change.
// - i_abort same cycle as confEnd with shadow valid -> ABORT (reset=1), IDLE next, cnt unchanged, shadow empty.
// - CNTW=2, 5 configurations -> o_confCnt 1,2,3,0,1; o_confDone 5 single-cycle pulses.

Source files
------------

// File: rtl/pe_conf_sequencer_pkg.sv
// Shared types for the PE column configuration sequencer: descriptor, controller
// instruction/status and sequencer state encodings.
package pe_conf_sequencer_pkg;

    typedef struct packed {
        logic [7:0] layer;
        logic [7:0] tile;
        logic [7:0] loops;
    } conf_t;

    typedef struct packed {
        logic dval;
        logic start;
        logic reset;
        logic next;
        logic stall;
    } inst_t;

    typedef struct packed {
        logic confEnd;
    } dpstatus_t;

    localparam logic [2:0] SEQ_IDLE  = 3'd0;
    localparam logic [2:0] SEQ_START = 3'd1;
    localparam logic [2:0] SEQ_WARM  = 3'd2;
    localparam logic [2:0] SEQ_RUN   = 3'd3;
    localparam logic [2:0] SEQ_ABORT = 3'd4;

endpackage

// File: rtl/pe_conf_slot.sv
// Single-entry shadow register for the next configuration descriptor.
// Flush beats load beats take; load and take are never requested together.
module pe_conf_slot
    import pe_conf_sequencer_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  take,
    input  logic  flush,
    input  conf_t conf_in,
    output logic  valid,
    output conf_t conf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            conf  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (take)
                valid <= 1'b0;
            if (load && !flush)
                conf <= conf_in;
        end
    end

endmodule

// File: rtl/pe_conf_sequencer.sv
// Walks one PE column's datapath controller through queued configurations:
// start/reset kick, warm-up, run with stall forwarding, completion counting and abort.
module pe_conf_sequencer
    import pe_conf_sequencer_pkg::*;
#(
    parameter int CNTW     = 8,
    parameter bit PREFETCH = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            Conf_rdy,
    output logic            Conf_ack,
    input  conf_t           i_conf,
    input  logic            i_hold,
    input  logic            i_abort,
    input  dpstatus_t       i_dpstatus,
    output conf_t           o_PEconf,
    output inst_t           o_PEinst,
    output logic            o_busy,
    output logic            o_confDone,
    output logic [CNTW-1:0] o_confCnt
);

    logic [2:0] state, state_nx;
    logic       armed;
    logic       shadow_v;
    conf_t      shadow;
    logic       load, take, end_hit, done_nx;

    assign Conf_ack = !shadow_v && !i_abort && ((PREFETCH != 1'b0) || state == SEQ_IDLE);
    assign load     = Conf_rdy && Conf_ack;
    // The controller holds confEnd across idle, so only trust it once a RUN cycle has passed.
    assign end_hit  = i_dpstatus.confEnd && armed;
    assign done_nx  = (state == SEQ_RUN) && !i_abort && end_hit;
    assign o_busy   = (state != SEQ_IDLE) || shadow_v;

    pe_conf_slot u_slot (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .load    (load),
        .take    (take),
        .flush   (i_abort),
        .conf_in (i_conf),
        .valid   (shadow_v),
        .conf    (shadow)
    );

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (shadow_v && !i_abort) begin
                    state_nx = SEQ_START;
                    take     = 1'b1;
                end
            end
            SEQ_START: state_nx = i_abort ? SEQ_ABORT : SEQ_WARM;
            SEQ_WARM:  state_nx = i_abort ? SEQ_ABORT : SEQ_RUN;
            SEQ_RUN: begin
                if (i_abort)
                    state_nx = SEQ_ABORT;
                else if (end_hit) begin
                    state_nx = shadow_v ? SEQ_START : SEQ_IDLE;
                    take     = shadow_v;
                end
            end
            default: state_nx = SEQ_IDLE;
        endcase
    end

    always_comb begin
        o_PEinst = '0;
        case (state)
            SEQ_START: begin
                o_PEinst.dval  = 1'b1;
                o_PEinst.start = 1'b1;
                o_PEinst.reset = 1'b1;
            end
            SEQ_WARM: o_PEinst.dval = 1'b1;
            SEQ_RUN: begin
                o_PEinst.dval  = 1'b1;
                o_PEinst.stall = i_hold;
            end
            SEQ_ABORT: begin
                o_PEinst.dval  = 1'b1;
                o_PEinst.reset = 1'b1;
            end
            default: o_PEinst = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= SEQ_IDLE;
            armed      <= 1'b0;
            o_PEconf   <= '0;
            o_confDone <= 1'b0;
            o_confCnt  <= '0;
        end else begin
            state      <= state_nx;
            armed      <= (state == SEQ_RUN);
            o_confDone <= done_nx;
            if (take)
                o_PEconf <= shadow;
            if (done_nx)
                o_confCnt <= o_confCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_conf_sequencer.sv
// Directed bench for pe_conf_sequencer (CNTW=2, PREFETCH=1) with hand-computed expectations.
module tb_pe_conf_sequencer;
    import pe_conf_sequencer_pkg::*;

    localparam int CNTW = 2;
    localparam logic [4:0] I_IDLE  = 5'b00000;
    localparam logic [4:0] I_START = 5'b11100;
    localparam logic [4:0] I_RUN   = 5'b10000;
    localparam logic [4:0] I_STALL = 5'b10001;
    localparam logic [4:0] I_ABORT = 5'b10100;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            conf_rdy = 1'b0;
    logic            conf_ack;
    conf_t           conf = '0;
    logic            hold = 1'b0;
    logic            abort = 1'b0;
    dpstatus_t       dpstatus = '0;
    conf_t           peconf;
    inst_t           peinst;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] cnt;

    int tests = 0;
    int fails = 0;

    pe_conf_sequencer #(.CNTW(CNTW), .PREFETCH(1'b1)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .Conf_rdy   (conf_rdy),
        .Conf_ack   (conf_ack),
        .i_conf     (conf),
        .i_hold     (hold),
        .i_abort    (abort),
        .i_dpstatus (dpstatus),
        .o_PEconf   (peconf),
        .o_PEinst   (peinst),
        .o_busy     (busy),
        .o_confDone (done),
        .o_confCnt  (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full configuration from IDLE: accept, START, WARM, two RUN cycles, confEnd.
    task automatic run_conf(input conf_t c, input logic [CNTW-1:0] exp_cnt);
        conf_rdy = 1'b1; conf = c;
        #1 check("w_ack", 32'(conf_ack), 32'd1);
        step(); conf_rdy = 1'b0;
        step();
        check("w_start", 32'(peinst), 32'(I_START));
        check("w_conf", 32'(peconf), 32'(c));
        step(); step(); step();
        dpstatus.confEnd = 1'b1;
        step(); dpstatus.confEnd = 1'b0;
        check("w_done", 32'(done), 32'd1);
        check("w_cnt", 32'(cnt), 32'(exp_cnt));
        step();
        check("w_done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        // reset state
        step(); step();
        check("rst_inst", 32'(peinst), 32'(I_IDLE));
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_conf", 32'(peconf), 32'd0);
        rstn = 1'b1;
        step();

        // single configuration, no hold
        conf_rdy = 1'b1; conf = 24'hA10203;
        #1 check("t1_ack", 32'(conf_ack), 32'd1);
        step(); conf_rdy = 1'b0;
        check("t1_idle_inst", 32'(peinst), 32'(I_IDLE));
        check("t1_busy", 32'(busy), 32'd1);
        step();
        check("t1_start", 32'(peinst), 32'(I_START));
        check("t1_conf", 32'(peconf), 32'hA10203);
        step();
        check("t1_warm", 32'(peinst), 32'(I_RUN));
        step();
        check("t1_run", 32'(peinst), 32'(I_RUN));
        step();
        dpstatus.confEnd = 1'b1;
        step(); dpstatus.confEnd = 1'b0;
        check("t1_end_inst", 32'(peinst), 32'(I_IDLE));
        check("t1_done", 32'(done), 32'd1);
        check("t1_cnt", 32'(cnt), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        step();
        check("t1_done_clr", 32'(done), 32'd0);

        // two queued configurations, back-to-back issue
        conf_rdy = 1'b1; conf = 24'hB00001;
        step(); conf_rdy = 1'b0;
        step();
        check("t2_conf_b", 32'(peconf), 32'hB00001);
        step();
        conf_rdy = 1'b1; conf = 24'hC00002;
        #1 check("t2_ack_prefetch", 32'(conf_ack), 32'd1);
        step();
        conf = 24'hD00003;
        #1 check("t2_ack_full", 32'(conf_ack), 32'd0);
        step(); conf_rdy = 1'b0;
        check("t2_conf_hold", 32'(peconf), 32'hB00001);
        dpstatus.confEnd = 1'b1;
        step();
        check("t2_b2b_start", 32'(peinst), 32'(I_START));
        check("t2_conf_c", 32'(peconf), 32'hC00002);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cnt", 32'(cnt), 32'd2);

        // stale confEnd still high at entry to RUN is ignored
        step(); step();
        check("t3_done_low", 32'(done), 32'd0);
        step(); dpstatus.confEnd = 1'b0;
        check("t3_still_run", 32'(peinst), 32'(I_RUN));
        check("t3_cnt", 32'(cnt), 32'd2);

        // hold in RUN for 5 cycles
        for (int i = 0; i < 5; i++) begin
            hold = 1'b1;
            #1 check("t4_stall", 32'(peinst), 32'(I_STALL));
            step();
        end
        hold = 1'b0;
        #1 check("t4_unstall", 32'(peinst), 32'(I_RUN));
        check("t4_cnt", 32'(cnt), 32'd2);
        dpstatus.confEnd = 1'b1;
        step(); dpstatus.confEnd = 1'b0;
        check("t3_done", 32'(done), 32'd1);
        check("t3_cnt_end", 32'(cnt), 32'd3);
        check("t3_idle", 32'(peinst), 32'(I_IDLE));
        check("t3_busy", 32'(busy), 32'd0);

        // hold not forwarded in START/WARM; abort beats confEnd
        conf_rdy = 1'b1; conf = 24'hE00004;
        step(); conf_rdy = 1'b0;
        step();
        hold = 1'b1;
        #1 check("t5_hold_start", 32'(peinst), 32'(I_START));
        step();
        check("t5_hold_warm", 32'(peinst), 32'(I_RUN));
        hold = 1'b0;
        conf_rdy = 1'b1; conf = 24'hF00005;
        #1 check("t5_ack_f", 32'(conf_ack), 32'd1);
        step(); conf_rdy = 1'b0;
        step();
        dpstatus.confEnd = 1'b1; abort = 1'b1;
        #1 check("t5_ack_abort", 32'(conf_ack), 32'd0);
        step(); dpstatus.confEnd = 1'b0; abort = 1'b0;
        check("t5_abort_inst", 32'(peinst), 32'(I_ABORT));
        check("t5_abort_done", 32'(done), 32'd0);
        check("t5_abort_cnt", 32'(cnt), 32'd3);
        step();
        check("t5_idle", 32'(peinst), 32'(I_IDLE));
        check("t5_busy", 32'(busy), 32'd0);
        step();
        check("t5_no_restart", 32'(peinst), 32'(I_IDLE));
        check("t5_conf_kept", 32'(peconf), 32'hE00004);

        // counter wrap with CNTW=2
        rstn = 1'b0;
        #1 check("t6_rst_cnt", 32'(cnt), 32'd0);
        step(); rstn = 1'b1;
        step();
        run_conf(24'h010101, 2'd1);
        run_conf(24'h020202, 2'd2);
        run_conf(24'h030303, 2'd3);
        run_conf(24'h040404, 2'd0);
        run_conf(24'h050505, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
